// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused across WIDTH
// clock cycles, LSB first, with valid/ready handshakes on operands and result.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for operands; last result still presented on s/cout/ovf
//   RUN   | processing one bit per clock, counter tracks the bit index
//   DONE  | result valid, held until out_ready
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] ra, rb, res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_r, ovf_r;

    // Full adder built from two half adders and an OR.
    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

    always_comb begin
        ha0_s = ra[0] ^ rb[0];
        ha0_c = ra[0] & rb[0];
        ha1_s = ha0_s ^ carry;
        ha1_c = ha0_s & carry;
        fa_c  = ha0_c | ha1_c;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    ra    <= {1'b0, ra[WIDTH-1:1]};
                    rb    <= {1'b0, rb[WIDTH-1:1]};
                    res   <= {ha1_s, res[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    // carry still holds the carry into the MSB on the last bit
                    if (cnt == LAST) begin
                        cout_r <= fa_c;
                        ovf_r  <= carry ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = res;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl (WIDTH=8) against
// hand-computed vectors and a small arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int cons_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready)   acc_cnt++;
        if (!rst && out_valid && out_ready) cons_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: A + (B ^ mask) + sub over W+1 bits.
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rsub,
                             output logic [W-1:0] es, output logic ec, output logic eo);
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = rb ^ {W{rsub}};
        full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, rsub};
        es   = full[W-1:0];
        ec   = full[W];
        eo   = (ra[W-1] == bb[W-1]) && (es[W-1] != ra[W-1]);
    endtask

    // Present operands until accepted; returns at the negedge after acceptance.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
        a = va; b = vb; sub = vsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check_val("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic consume(input int gap);
        out_ready = 1'b0;
        repeat (gap) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic dir_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vsub, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        send(va, vb, vsub);
        wait_valid(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'd8);
        check_val({tag, "_s"}, 32'(s), 32'(es));
        check_val({tag, "_cout"}, 32'(cout), 32'(ec));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(eo));
        consume(0);
    endtask

    initial begin
        int lat;
        int acc0, cons0;
        logic [W-1:0] ra, rb, es;
        logic rsub, ec, eo;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_s", 32'(s), 32'd0);
        check_val("rst_cout", 32'(cout), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);

        dir_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        check_val("idle_keeps_s", 32'(s), 32'h80);
        check_val("idle_in_ready", 32'(in_ready), 32'd1);
        dir_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        dir_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        dir_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure in DONE
        send(8'h40, 8'h40, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            check_val("bp_busy", 32'(busy), 32'd1);
            check_val("bp_s", 32'(s), 32'h80);
            check_val("bp_cout", 32'(cout), 32'd0);
            check_val("bp_ovf", 32'(ovf), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_rel_out_valid", 32'(out_valid), 32'd0);
        check_val("bp_rel_in_ready", 32'(in_ready), 32'd1);

        // in_valid held high with changing operands during RUN/DONE
        a = 8'h11; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h55; b = 8'h66;
        check_val("hold_in_ready_run", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check_val("hold_lat", 32'(lat), 32'd8);
        check_val("hold_first_s", 32'(s), 32'h33);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("hold_idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("hold_second_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check_val("hold_second_lat", 32'(lat), 32'd8);
        check_val("hold_second_s", 32'(s), 32'hBB);
        consume(0);

        // Reset mid-RUN
        send(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_s", 32'(s), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        dir_op("post_rst_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Randomized regression
        acc0 = acc_cnt; cons0 = cons_cnt;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rsub = 1'($urandom);
            ref_model(ra, rb, rsub, es, ec, eo);
            send(ra, rb, rsub);
            wait_valid(lat);
            check_val("rnd_s", 32'(s), 32'(es));
            check_val("rnd_cout", 32'(cout), 32'(ec));
            check_val("rnd_ovf", 32'(ovf), 32'(eo));
            consume($urandom_range(0, 3));
        end
        check_val("rnd_accept_count", 32'(acc_cnt - acc0), 32'd1000);
        check_val("rnd_consume_count", 32'(cons_cnt - cons0), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
